// File: rtl/fft_pkg.sv
// Shared sizing, FSM state type and butterfly address helper for the FFT
// address-generation unit and anything that needs to reproduce its addressing.
package fft_pkg;

   localparam int N_LOG2  = 5;
   localparam int N       = 1 << N_LOG2;
   localparam int HALF    = N / 2;
   localparam int ADDR_W  = N_LOG2;
   localparam int TW_W    = N_LOG2 - 1;
   localparam int STAGE_W = $clog2(N_LOG2);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } fsm_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [ADDR_W-1:0] b;
      logic [TW_W-1:0]   tw;
   } bfu_addr_t;

   // Butterfly j of a stage pairs g at a and h at a+span; the offset inside
   // the group scaled up to the N/2-entry ROM selects the twiddle.
   function automatic bfu_addr_t bfu_addr(input logic [TW_W-1:0]    j,
                                          input logic [STAGE_W-1:0] stage);
      bfu_addr_t         r;
      logic [ADDR_W-1:0] jx;
      logic [ADDR_W-1:0] span;
      logic [ADDR_W-1:0] mask;
      logic [ADDR_W-1:0] off;
      jx   = ADDR_W'(j);
      span = ADDR_W'(1) << stage;
      mask = span - ADDR_W'(1);
      off  = jx & mask;
      r.a  = ((jx >> stage) << (stage + 1)) | off;
      r.b  = r.a | span;
      r.tw = TW_W'(off << (TW_W - int'(stage)));
      return r;
   endfunction

endpackage

// File: rtl/fft_agu_if.sv
// Control and memory-addressing bundle between the FFT sequencer, the data
// RAM / twiddle ROM and whoever launches the transform.
interface fft_agu_if;
   import fft_pkg::*;

   logic                start;
   logic                busy;
   logic                done;
   logic [STAGE_W-1:0]  stage;
   logic                rd_en;
   logic [ADDR_W-1:0]   rd_addr_a;
   logic [ADDR_W-1:0]   rd_addr_b;
   logic [TW_W-1:0]     tw_addr;
   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr_a;
   logic [ADDR_W-1:0]   wr_addr_b;

   modport master (
      input  start,
      output busy, done, stage,
      output rd_en, rd_addr_a, rd_addr_b, tw_addr,
      output wr_en, wr_addr_a, wr_addr_b
   );

   modport slave (
      output start,
      input  busy, done, stage,
      input  rd_en, rd_addr_a, rd_addr_b, tw_addr,
      input  wr_en, wr_addr_a, wr_addr_b
   );

endinterface

// File: rtl/fft_addr_delay.sv
// Fixed-depth shift register that carries read strobes and addresses forward
// so they become write strobes/addresses aligned to the butterfly output.
module fft_addr_delay
   import fft_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              src_valid,
   input  logic [ADDR_W-1:0] src_a,
   input  logic [ADDR_W-1:0] src_b,
   output logic              dly_valid,
   output logic [ADDR_W-1:0] dly_a,
   output logic [ADDR_W-1:0] dly_b
);

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] a;
      logic [ADDR_W-1:0] b;
   } tap_t;

   tap_t taps [DEPTH];

   // Shifts every cycle whatever the sequencer is doing, so in-flight
   // butterflies still retire while reads are paused.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            taps[i] <= '0;
         end
      end else begin
         taps[0] <= '{valid: src_valid, a: src_a, b: src_b};
         for (int i = 1; i < DEPTH; i++) begin
            taps[i] <= taps[i-1];
         end
      end
   end

   assign dly_valid = taps[DEPTH-1].valid;
   assign dly_a     = taps[DEPTH-1].a;
   assign dly_b     = taps[DEPTH-1].b;

endmodule

// File: rtl/fft_agu.sv
// In-place radix-2 DIT FFT sequencer: walks all stages issuing one butterfly
// read per cycle and replays the addresses as write-backs after the pipeline.
module fft_agu
   import fft_pkg::*;
#(
   parameter int RD_LAT  = 1,
   parameter int BFU_LAT = 1
) (
   input logic       clk,
   input logic       reset,
   fft_agu_if.master bus
);

   localparam int WB_LAT  = RD_LAT + BFU_LAT;
   localparam int DRAIN_W = $clog2(WB_LAT + 1);

   localparam logic [TW_W-1:0]    J_LAST     = TW_W'(HALF - 1);
   localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(N_LOG2 - 1);
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(WB_LAT - 1);

   fsm_state_t         state;
   fsm_state_t         state_next;
   logic [TW_W-1:0]    j;
   logic [TW_W-1:0]    j_next;
   logic [STAGE_W-1:0] stage_q;
   logic [STAGE_W-1:0] stage_next;
   logic [DRAIN_W-1:0] drain_cnt;
   logic [DRAIN_W-1:0] drain_next;

   logic               rd_en_q;
   logic               busy_q;
   logic               done_q;
   bfu_addr_t          issue_q;
   bfu_addr_t          issue_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         j         <= '0;
         stage_q   <= '0;
         drain_cnt <= '0;
      end else begin
         state     <= state_next;
         j         <= j_next;
         stage_q   <= stage_next;
         drain_cnt <= drain_next;
      end
   end

   // The pause after each stage equals the write-back latency, so the next
   // stage never reads a location whose previous-stage result is in flight.
   always_comb begin
      state_next = state;
      j_next     = j;
      stage_next = stage_q;
      drain_next = drain_cnt;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_next = RUN;
               j_next     = '0;
               stage_next = '0;
            end
         end
         RUN: begin
            if (j == J_LAST) begin
               state_next = DRAIN;
               drain_next = '0;
            end else begin
               j_next = j + TW_W'(1);
            end
         end
         DRAIN: begin
            if (drain_cnt == DRAIN_LAST) begin
               if (stage_q == STAGE_LAST) begin
                  state_next = DONE;
               end else begin
                  state_next = RUN;
                  stage_next = stage_q + STAGE_W'(1);
                  j_next     = '0;
               end
            end else begin
               drain_next = drain_cnt + DRAIN_W'(1);
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign issue_next = bfu_addr(j_next, stage_next);

   // Outputs are registered from the next-state view so the strobe and the
   // addresses it qualifies leave on the same edge as the state change.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_en_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         issue_q <= '0;
      end else begin
         rd_en_q <= (state_next == RUN);
         busy_q  <= (state_next == RUN) || (state_next == DRAIN);
         done_q  <= (state_next == DONE);
         if (state_next == RUN) begin
            issue_q <= issue_next;
         end
      end
   end

   fft_addr_delay #(
      .DEPTH (WB_LAT)
   ) u_delay (
      .clk       (clk),
      .reset     (reset),
      .src_valid (rd_en_q),
      .src_a     (issue_q.a),
      .src_b     (issue_q.b),
      .dly_valid (bus.wr_en),
      .dly_a     (bus.wr_addr_a),
      .dly_b     (bus.wr_addr_b)
   );

   assign bus.rd_en     = rd_en_q;
   assign bus.rd_addr_a = issue_q.a;
   assign bus.rd_addr_b = issue_q.b;
   assign bus.tw_addr   = issue_q.tw;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.stage     = stage_q;

endmodule

// File: tb/tb_fft_agu.sv
// Self-checking bench for fft_agu: a cycle-position model of the whole
// transform plus a write/read scoreboard, driven by directed and random starts.
module tb_fft_agu;
   import fft_pkg::*;

   localparam int WB      = 2;
   localparam int SLOT    = HALF + WB;
   localparam int RUN_LEN = N_LOG2 * SLOT;

   logic clk = 1'b0;
   logic reset;

   fft_agu_if bus ();

   fft_agu #(
      .RD_LAT  (1),
      .BFU_LAT (1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int rel      = -1;
   int cycle    = 0;
   int wrCount [N];
   int rdPulses = 0;
   int wrPulses = 0;
   int firstRd  = 0;
   bit runSeen  = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d, rel %0d)",
                  name, actual, expected, cycle, rel);
      end
   endtask

   // Butterfly j of stage s: group j/span, offset j%span, partner span away,
   // twiddle exponent is the offset scaled by N/(2*span).
   function automatic void refAddr(input int s, input int jj,
                                   output int a, output int b, output int tw);
      int span;
      span = 1 << s;
      a    = (jj / span) * 2 * span + (jj % span);
      b    = a + span;
      tw   = (jj % span) * (HALF / span);
   endfunction

   always @(posedge clk) cycle <= cycle + 1;

   // Position of the current cycle inside a run; -1 means idle.
   always @(posedge clk or posedge reset) begin
      if (reset)                rel <= -1;
      else if (rel < 0) begin
         if (bus.start)         rel <= 0;
      end
      else if (rel == RUN_LEN)  rel <= -1;
      else                      rel <= rel + 1;
   end

   task automatic checkReset(input string tag);
      checkOutput({tag, " rd_en"},     bus.rd_en,     0);
      checkOutput({tag, " wr_en"},     bus.wr_en,     0);
      checkOutput({tag, " busy"},      bus.busy,      0);
      checkOutput({tag, " done"},      bus.done,      0);
      checkOutput({tag, " stage"},     bus.stage,     0);
      checkOutput({tag, " rd_addr_a"}, bus.rd_addr_a, 0);
      checkOutput({tag, " rd_addr_b"}, bus.rd_addr_b, 0);
      checkOutput({tag, " tw_addr"},   bus.tw_addr,   0);
      checkOutput({tag, " wr_addr_a"}, bus.wr_addr_a, 0);
      checkOutput({tag, " wr_addr_b"}, bus.wr_addr_b, 0);
   endtask

   task automatic pinAddr(input int a, input int b, input int tw);
      checkOutput("pin rd_addr_a", bus.rd_addr_a, a);
      checkOutput("pin rd_addr_b", bus.rd_addr_b, b);
      checkOutput("pin tw_addr",   bus.tw_addr,   tw);
   endtask

   task automatic compareCycle();
      int   s, p, q, a, b, tw, bad;
      logic expRd, expWr, expBusy, expDone;
      s = 0; p = 0; q = 0; expRd = 0; expWr = 0; expBusy = 0;
      if (rel == 0) begin
         foreach (wrCount[i]) wrCount[i] = 0;
         rdPulses = 0;
         wrPulses = 0;
      end
      if (rel >= 0 && rel < RUN_LEN) begin
         s       = rel / SLOT;
         p       = rel % SLOT;
         expBusy = 1;
         expRd   = (p < HALF);
         q       = rel - WB;
         expWr   = (q >= 0) && ((q % SLOT) < HALF);
      end
      expDone = (rel == RUN_LEN);
      checkOutput("rd_en", bus.rd_en, expRd);
      checkOutput("wr_en", bus.wr_en, expWr);
      checkOutput("busy",  bus.busy,  expBusy);
      checkOutput("done",  bus.done,  expDone);
      if (expBusy) checkOutput("stage", bus.stage, s);
      if (expRd) begin
         refAddr(s, p, a, b, tw);
         checkOutput("rd_addr_a", bus.rd_addr_a, a);
         checkOutput("rd_addr_b", bus.rd_addr_b, b);
         checkOutput("tw_addr",   bus.tw_addr,   tw);
      end
      if (expWr) begin
         refAddr(q / SLOT, q % SLOT, a, b, tw);
         checkOutput("wr_addr_a", bus.wr_addr_a, a);
         checkOutput("wr_addr_b", bus.wr_addr_b, b);
      end
      case (rel)
         0:       pinAddr(0, 1, 0);
         5:       pinAddr(10, 11, 0);
         41:      pinAddr(9, 13, 4);
         77:      pinAddr(5, 21, 5);
         default: ;
      endcase
      // Reads before writes: a read in stage s must see exactly s earlier writes.
      if (bus.rd_en && expBusy) begin
         checkOutput("read-after-write a", wrCount[bus.rd_addr_a], s);
         checkOutput("read-after-write b", wrCount[bus.rd_addr_b], s);
         rdPulses++;
         if (!runSeen) begin
            runSeen = 1'b1;
            firstRd = cycle;
         end
      end
      if (bus.wr_en) begin
         wrCount[bus.wr_addr_a]++;
         wrCount[bus.wr_addr_b]++;
         wrPulses++;
      end
      if (bus.done) begin
         checkOutput("done latency", cycle - firstRd, RUN_LEN);
         runSeen = 1'b0;
      end
      if (expDone) begin
         bad = 0;
         foreach (wrCount[i]) if (wrCount[i] != N_LOG2) bad++;
         checkOutput("rd_en pulses",   rdPulses, N_LOG2 * HALF);
         checkOutput("wr_en pulses",   wrPulses, N_LOG2 * HALF);
         checkOutput("write coverage", bad,      0);
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         checkReset("reset");
         runSeen = 1'b0;
      end else begin
         compareCycle();
      end
   end

   task automatic applyStimulus(input logic s);
      @(posedge clk);
      #1 bus.start = s;
   endtask

   task automatic waitDone(input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(posedge clk);
         #1 seen = bus.done;
      end
      if (!seen) checkOutput("done timeout", 0, 1);
   endtask

   initial begin
      reset     = 1'b1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      $display("[TB] full run with start repeated while busy");
      applyStimulus(1'b1);
      applyStimulus(1'b0);
      repeat (20) applyStimulus(1'b0);
      repeat (3) applyStimulus(1'b1);
      applyStimulus(1'b0);
      waitDone(200);
      bus.start = 1'b1;
      applyStimulus(1'b0);
      repeat (5) applyStimulus(1'b0);

      $display("[TB] reset at stage 2, j 7");
      applyStimulus(1'b1);
      applyStimulus(1'b0);
      begin
         bit hit;
         hit = 1'b0;
         for (int i = 0; i < 200 && !hit; i++) begin
            @(posedge clk);
            #1 hit = (rel == 2 * SLOT + 7);
         end
         if (!hit) checkOutput("reach stage 2 j 7", 0, 1);
      end
      reset = 1'b1;
      #1 checkReset("abort");
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (10) applyStimulus(1'b0);

      $display("[TB] random start traffic");
      for (int i = 0; i < 1500; i++) begin
         applyStimulus(($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
      end
      applyStimulus(1'b0);
      begin
         bit idle;
         idle = 1'b0;
         for (int i = 0; i < 200 && !idle; i++) begin
            @(posedge clk);
            #1 idle = (rel < 0) && !bus.busy;
         end
         if (!idle) checkOutput("final idle timeout", 0, 1);
      end
      repeat (3) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
